pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the ID/EX hazard sources and the hazard controller.
// The master side drives the decode/execute observations; the slave side returns pipeline controls.
interface pipeline_hazard_ctrl_if;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic [3:0] ex_rd;
    logic       ex_mem_read;
    logic       id_is_mul;
    logic       branch_taken;
    logic       halt_instr;
    logic       resume;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush_n;
    logic       id_ex_load;
    logic [2:0] ctrl_state;
    logic [1:0] mul_cnt;

    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read, id_is_mul, branch_taken, halt_instr, resume,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush_n, id_ex_load, ctrl_state, mul_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_mem_read, id_is_mul, branch_taken, halt_instr, resume,
        output pc_write, if_id_write, if_id_flush, id_ex_flush_n, id_ex_load, ctrl_state, mul_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-state pipeline hazard controller: load-use stall, multiply freeze, branch flush and HALT.
// State is registered; controls are decoded combinationally so a hazard acts in the cycle it is seen.
module pipeline_hazard_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_RUN        = 3'd0,
        S_LOAD_STALL = 3'd1,
        S_MUL_WAIT   = 3'd2,
        S_BR_FLUSH   = 3'd3,
        S_HALTED     = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] mul_cnt_r;
    logic [1:0] mul_cnt_nxt_s;
    logic       load_use_s;
    logic       pc_write_s;
    logic       if_id_write_s;
    logic       if_id_flush_s;
    logic       id_ex_flush_n_s;
    logic       id_ex_load_s;

    // Load-use detection; register 0 is hardwired and never a hazard.
    always_comb begin
        load_use_s = bus.ex_mem_read && (bus.ex_rd != 4'd0) &&
                     ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
    end

    // Next-state and control decode; the default arm serves RUN and the unused encodings 5-7.
    always_comb begin
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_flush_n_s = 1'b1;
        id_ex_load_s    = 1'b1;
        state_nxt_s     = state_r;
        mul_cnt_nxt_s   = mul_cnt_r;
        case (state_r)
            S_BR_FLUSH: begin
                if_id_flush_s = 1'b1;
                state_nxt_s   = S_RUN;
            end
            S_LOAD_STALL: begin
                if (bus.branch_taken) begin
                    if_id_write_s   = 1'b0;
                    if_id_flush_s   = 1'b1;
                    id_ex_flush_n_s = 1'b0;
                    state_nxt_s     = S_BR_FLUSH;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_MUL_WAIT: begin
                pc_write_s      = 1'b0;
                if_id_write_s   = 1'b0;
                id_ex_flush_n_s = 1'b0;
                // The <= also recovers from a corrupted zero count instead of wrapping to 3.
                if (mul_cnt_r <= 2'd1) begin
                    state_nxt_s   = S_RUN;
                    mul_cnt_nxt_s = 2'd0;
                end else begin
                    mul_cnt_nxt_s = mul_cnt_r - 2'd1;
                end
            end
            S_HALTED: begin
                pc_write_s      = 1'b0;
                if_id_write_s   = 1'b0;
                id_ex_flush_n_s = 1'b0;
                if (bus.resume) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_HALTED;
                end
            end
            default: begin
                if (bus.branch_taken) begin
                    if_id_write_s   = 1'b0;
                    if_id_flush_s   = 1'b1;
                    id_ex_flush_n_s = 1'b0;
                    state_nxt_s     = S_BR_FLUSH;
                end else if (load_use_s) begin
                    pc_write_s      = 1'b0;
                    if_id_write_s   = 1'b0;
                    id_ex_flush_n_s = 1'b0;
                    state_nxt_s     = S_LOAD_STALL;
                end else if (bus.id_is_mul) begin
                    mul_cnt_nxt_s = 2'd3;
                    state_nxt_s   = S_MUL_WAIT;
                end else if (bus.halt_instr) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    state_nxt_s   = S_HALTED;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
        endcase
    end

    // State and multiply counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_RUN;
            mul_cnt_r <= 2'd0;
        end else begin
            state_r   <= state_nxt_s;
            mul_cnt_r <= mul_cnt_nxt_s;
        end
    end

    // Reset overrides the decode so the pipeline is held flushed while rst is high.
    always_comb begin
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.if_id_flush   = 1'b1;
            bus.id_ex_flush_n = 1'b0;
            bus.id_ex_load    = 1'b0;
        end else begin
            bus.pc_write      = pc_write_s;
            bus.if_id_write   = if_id_write_s;
            bus.if_id_flush   = if_id_flush_s;
            bus.id_ex_flush_n = id_ex_flush_n_s;
            bus.id_ex_load    = id_ex_load_s;
        end
        bus.ctrl_state = state_r;
        bus.mul_cnt    = mul_cnt_r;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: the driver queues the expected controls for
// each cycle it drives, and a monitor on the falling edge pops and compares them.
module tb_pipeline_hazard_ctrl;
    // Expected control patterns as {pc_write, if_id_write, if_id_flush, id_ex_flush_n, id_ex_load}.
    localparam logic [4:0] IDLE = 5'b11011;
    localparam logic [4:0] RSTO = 5'b00100;
    localparam logic [4:0] BRAN = 5'b10101;
    localparam logic [4:0] BRFL = 5'b11111;
    localparam logic [4:0] FRZ  = 5'b00001;
    localparam logic [4:0] HLTI = 5'b00011;

    typedef struct {
        string      name;
        logic [4:0] o;
        logic [2:0] st;
        logic [1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pipeline_hazard_ctrl_if hif();

    pipeline_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic v(input string name, input logic r,
                     input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                     input logic mr, input logic mul, input logic br, input logic hlt, input logic res,
                     input logic [4:0] o, input logic [2:0] st, input logic [1:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        hif.id_rs1       = rs1;
        hif.id_rs2       = rs2;
        hif.ex_rd        = rd;
        hif.ex_mem_read  = mr;
        hif.id_is_mul    = mul;
        hif.branch_taken = br;
        hif.halt_instr   = hlt;
        hif.resume       = res;
        e.name = name;
        e.o    = o;
        e.st   = st;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] act;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_flush_n, hif.id_ex_load};
            checks++;
            if (act !== e.o || hif.ctrl_state !== e.st || hif.mul_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got ctrl=%b state=%0d cnt=%0d, expected ctrl=%b state=%0d cnt=%0d",
                         e.name, act, hif.ctrl_state, hif.mul_cnt, e.o, e.st, e.cnt);
            end
        end
    end

    initial begin
        hif.id_rs1 = 4'd0; hif.id_rs2 = 4'd0; hif.ex_rd = 4'd0; hif.ex_mem_read = 1'b0;
        hif.id_is_mul = 1'b0; hif.branch_taken = 1'b0; hif.halt_instr = 1'b0; hif.resume = 1'b0;

        //  name          rst   rs1    rs2    rd    mr    mul   br    hlt   res   ctrl  st    cnt
        v("reset",        1'b1, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RSTO, 3'd0, 2'd0);
        v("idle",         1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        // Load-use on rs2; the hazard is held through LOAD_STALL, which must not re-stall.
        v("lu_rs2",       1'b0, 4'd1,  4'd5,  4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FRZ,  3'd0, 2'd0);
        v("lu_stall",     1'b0, 4'd1,  4'd5,  4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd1, 2'd0);
        v("lu_ret",       1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        v("no_match",     1'b0, 4'd7,  4'd3,  4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        v("not_load",     1'b0, 4'd5,  4'd5,  4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        v("r0_no_haz",    1'b0, 4'd0,  4'd2,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        v("r0_stay_run",  1'b0, 4'd0,  4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        // Multiply freeze with ignored branch/halt/resume noise.
        v("mul",          1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        v("mw3",          1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ,  3'd2, 2'd3);
        v("mw2",          1'b0, 4'd4,  4'd0,  4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FRZ,  3'd2, 2'd2);
        v("mw1",          1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ,  3'd2, 2'd1);
        v("mul_done",     1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        // Branch beats load-use; BR_FLUSH ignores the events still present.
        v("br_lu",        1'b0, 4'd5,  4'd0,  4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, BRAN, 3'd0, 2'd0);
        v("br_flush",     1'b0, 4'd5,  4'd0,  4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BRFL, 3'd3, 2'd0);
        v("br_ret",       1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        // Load-use beats multiply; then a branch resolved during LOAD_STALL.
        v("lu_over_mul",  1'b0, 4'd3,  4'd0,  4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FRZ,  3'd0, 2'd0);
        v("ls_branch",    1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BRAN, 3'd1, 2'd0);
        v("ls_br_flush",  1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BRFL, 3'd3, 2'd0);
        v("ls_br_ret",    1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        // HALT, five held cycles with ignored noise, then resume.
        v("halt",         1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, HLTI, 3'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            v("halted",   1'b0, 4'd0,  4'd0,  4'd0, 1'b0, i[0], 1'b1, 1'b1, 1'b0, FRZ,  3'd4, 2'd0);
        end
        v("resume",       1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ,  3'd4, 2'd0);
        v("resumed",      1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        // Reset in the middle of a multiply freeze, with mul_cnt at 2.
        v("mul2",         1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        v("mw3_b",        1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ,  3'd2, 2'd3);
        v("rst_in_mw",    1'b1, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RSTO, 3'd0, 2'd0);
        v("post_rst",     1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);
        // Reset out of HALTED.
        v("halt2",        1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, HLTI, 3'd0, 2'd0);
        v("halted2",      1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ,  3'd4, 2'd0);
        v("rst_in_halt",  1'b1, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RSTO, 3'd0, 2'd0);
        v("post_rst2",    1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd0, 2'd0);

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
